// File: rtl/disposition_mc_pkg.sv
// disposition_mc_pkg: shared types and helpers for the disposition stage.
//   - Pass, ContextCache control and data-interface request types.
//   - disposition_mc_a: the per-action condition/address record decoded from
//     the opcodes (MAX_RD read slots; the stage uses the first NUM_RD).
//   - cond_eval(): condition-code evaluation, resolve_id(): indirect id lookup.
package disposition_mc_pkg;

  localparam int unsigned ID_W       = 8;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned FLAGS_W    = 8;
  localparam int unsigned OPC_W      = 192;
  localparam int unsigned SHARED_U64 = 4;
  localparam int unsigned SH_IDX_W   = $clog2(SHARED_U64);
  localparam int unsigned MAX_RD     = 4;
  localparam int unsigned COND_W     = 4;
  localparam int unsigned FLAG_IDX_W = $clog2(FLAGS_W);

  // Base id of the shared.u64 window used for indirect exec/fork ids.
  localparam logic [ID_W-1:0]   sharedAddress_u64 = 8'h40;
  localparam logic [COND_W-1:0] COND_ALWAYS       = '1;

  typedef enum logic [1:0] {
    INFO_NONE = 2'd0,
    INFO_PASS = 2'd1,
    INFO_COPY = 2'd2,
    INFO_MOVE = 2'd3
  } exec_info_e;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  typedef struct packed {
    logic            active_thread;
    logic [ID_W-1:0] id;
  } system_t;

  typedef struct packed {
    logic [FLAGS_W-1:0] flags;
    logic [OPC_W-1:0]   opcodes;
  } thread_register_union_t;

  typedef struct packed {
    logic [SHARED_U64-1:0][63:0] u64;
  } shared_t;

  typedef struct packed {
    system_t                system;
    thread_register_union_t thread;
    shared_t                shared;
  } pipeline_pass_structure;

  typedef struct packed {
    logic            incoming;
    logic [ID_W-1:0] incoming_id;
    logic            sleep;
    logic            delete_thread;
    exec_info_e      execute_info;
    logic [ID_W-1:0] execute_id;
    exec_info_e      fork_info;
    logic [ID_W-1:0] fork_id;
  } ContextCache_Control;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [ID_W-1:0]   who;
  } read_request_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [63:0]       data;
  } write_request_t;

  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic [ADDR_W-1:0] address;
    logic [ID_W-1:0]   who;
  } rd_slot_t;

  typedef struct packed {
    logic [COND_W-1:0]   cond;
    logic [ADDR_W-1:0]   address;
    logic [SH_IDX_W-1:0] src;
  } wr_slot_t;

  typedef struct packed {
    logic [COND_W-1:0]       sleep_cond;
    logic [COND_W-1:0]       delete_cond;
    logic [COND_W-1:0]       exec_cond;
    logic [ID_W-1:0]         exec_id;
    exec_info_e              exec_info;
    logic [COND_W-1:0]       fork_cond;
    logic [ID_W-1:0]         fork_id;
    exec_info_e              fork_info;
    rd_slot_t [MAX_RD-1:0]   rd;
    wr_slot_t                wr;
  } disposition_mc_a;

  // 0 = never, 1..FLAGS_W = flags[c-1], all-ones = always, anything else never.
  function automatic logic cond_eval(input logic [FLAGS_W-1:0] flags,
                                     input logic [COND_W-1:0]  c);
    logic [COND_W-1:0] idx;
    idx       = c - 1'b1;
    cond_eval = 1'b0;
    if (c == COND_ALWAYS)
      cond_eval = 1'b1;
    else if (c != '0 && c <= COND_W'(FLAGS_W))
      cond_eval = flags[idx[FLAG_IDX_W-1:0]];
  endfunction

  // Ids inside the shared window are replaced by the low bits of that slot.
  function automatic logic [ID_W-1:0] resolve_id(input logic [ID_W-1:0] id,
                                                 input shared_t         sh);
    logic [ID_W-1:0] off;
    off        = id - sharedAddress_u64;
    resolve_id = id;
    if (id >= sharedAddress_u64 && off < ID_W'(SHARED_U64))
      resolve_id = sh.u64[off[SH_IDX_W-1:0]][ID_W-1:0];
  endfunction

endpackage

// File: rtl/disposition_mc_req_fifo.sv
// req_fifo: request FIFO with registered head and an occupancy FSM.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : store push_data (ignored when full)
//   push_data   : payload
//   pop_ready   : consumer takes the head this cycle (ignored when empty)
//   head        : current head, all-zero while empty
//   full        : no free slot
module req_fifo
  import disposition_mc_pkg::*;
#(
  parameter type         T          = logic,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop_ready,
  output T     head,
  output logic full
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  T            mem_q [FIFO_DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  fifo_state_e state_q, state_d;
  logic        do_push, do_pop;

  always_comb begin
    do_push  = push && (state_q != FIFO_FULL);
    do_pop   = pop_ready && (state_q != FIFO_EMPTY);
    wr_ptr_d = wr_ptr_q + ptr_t'(do_push);
    rd_ptr_d = rd_ptr_q + ptr_t'(do_pop);
    state_d  = state_q;
    case (state_q)
      FIFO_EMPTY:   if (do_push) state_d = FIFO_PARTIAL;
      FIFO_PARTIAL: begin
        // Equal low bits with differing wrap bit means full.
        if (do_push && !do_pop && wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0])
          state_d = FIFO_FULL;
        else if (do_pop && !do_push && wr_ptr_d == rd_ptr_d)
          state_d = FIFO_EMPTY;
      end
      FIFO_FULL:    if (do_pop) state_d = FIFO_PARTIAL;
      default:      state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= FIFO_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_comb begin
    head = (state_q == FIFO_EMPTY) ? T'('0) : mem_q[rd_ptr_q[AW-1:0]];
    full = (state_q == FIFO_FULL);
  end

endmodule

// File: rtl/disposition_mc.sv
// disposition_mc: last pipeline stage before the ContextCache and data interface.
// Decodes disposition_a from the pass opcodes, evaluates per-action conditions,
// registers ContextCache control and queues read/write requests in FIFOs.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : pass handshake; in_ready low while any FIFO is full
//   inputState        : pass being disposed
//   incoming_thread   : registered thread for the ContextCache
//   incoming_control  : registered ContextCache control
//   read_req[NUM_RD]  : read FIFO heads, read_ready[NUM_RD] pops them
//   write/write_ready : write FIFO head and its pop
// Optional (DISPOSITION_PERF_CNT_EN): stall_cnt, drop_cnt saturating counters.
module disposition_mc
  import disposition_mc_pkg::*;
#(
  parameter int unsigned addressStart = 8,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned NUM_FLAGS    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  pipeline_pass_structure inputState,
  output thread_register_union_t incoming_thread,
  output ContextCache_Control    incoming_control,
  output read_request_t          read_req [NUM_RD],
  input  logic                   read_ready [NUM_RD],
  output write_request_t         write,
  input  logic                   write_ready
`ifdef DISPOSITION_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            drop_cnt
`endif
);

  localparam int unsigned DISP_W = $bits(disposition_mc_a);
  // Flags above NUM_FLAGS read as zero so their codes evaluate to never.
  localparam logic [FLAGS_W-1:0] FLAG_MASK = {FLAGS_W{1'b1}} >> (FLAGS_W - NUM_FLAGS);

  disposition_mc_a        disp;
  logic [FLAGS_W-1:0]     flags;
  logic                   handshake, accept;
  logic                   rdy_q, rdy_d;
  thread_register_union_t thread_q, thread_d;
  ContextCache_Control    ctl_q, ctl_d;
  logic [NUM_RD:0]        fifo_full;
  logic                   wr_push;
  write_request_t         wr_data;
  logic                   unused_disp;

  always_comb begin
    disp        = disposition_mc_a'(inputState.thread.opcodes[addressStart +: DISP_W]);
    flags       = inputState.thread.flags & FLAG_MASK;
    unused_disp = ^disp;
    in_ready    = rdy_q && (fifo_full == '0);
    handshake   = in_valid && in_ready;
    accept      = handshake && inputState.system.active_thread;
  end

  always_comb begin
    rdy_d          = 1'b1;
    thread_d       = thread_q;
    ctl_d          = ctl_q;
    ctl_d.incoming = 1'b0;
    if (accept) begin
      thread_d            = inputState.thread;
      ctl_d.incoming      = 1'b1;
      ctl_d.incoming_id   = inputState.system.id;
      ctl_d.sleep         = cond_eval(flags, disp.sleep_cond);
      ctl_d.delete_thread = cond_eval(flags, disp.delete_cond);
      if (cond_eval(flags, disp.exec_cond)) begin
        ctl_d.execute_info = disp.exec_info;
        ctl_d.execute_id   = resolve_id(disp.exec_id, inputState.shared);
      end else begin
        ctl_d.execute_info = INFO_NONE;
        ctl_d.execute_id   = '0;
      end
      if (cond_eval(flags, disp.fork_cond)) begin
        ctl_d.fork_info = disp.fork_info;
        ctl_d.fork_id   = resolve_id(disp.fork_id, inputState.shared);
      end else begin
        ctl_d.fork_info = INFO_NONE;
        ctl_d.fork_id   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q    <= 1'b0;
      thread_q <= '0;
      ctl_q    <= '0;
    end else begin
      rdy_q    <= rdy_d;
      thread_q <= thread_d;
      ctl_q    <= ctl_d;
    end
  end

  always_comb begin
    incoming_thread  = thread_q;
    incoming_control = ctl_q;
  end

  // Channel 0 reads on behalf of the pass itself; others name their target.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic          push;
    read_request_t push_data;
    always_comb begin
      push      = accept && cond_eval(flags, disp.rd[k].cond);
      push_data = '{valid:   1'b1,
                    address: disp.rd[k].address,
                    who:     (k == 0) ? inputState.system.id : disp.rd[k].who};
    end
    req_fifo #(.T(read_request_t), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (push),
      .push_data (push_data),
      .pop_ready (read_ready[k]),
      .head      (read_req[k]),
      .full      (fifo_full[k])
    );
  end

  always_comb begin
    wr_push = accept && cond_eval(flags, disp.wr.cond);
    wr_data = '{valid:   1'b1,
                address: disp.wr.address,
                data:    inputState.shared.u64[disp.wr.src]};
  end

  req_fifo #(.T(write_request_t), .FIFO_DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (wr_push),
    .push_data (wr_data),
    .pop_ready (write_ready),
    .head      (write),
    .full      (fifo_full[NUM_RD])
  );

`ifdef DISPOSITION_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (in_valid && !in_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (handshake && !inputState.system.active_thread && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    stall_cnt = stall_cnt_q;
    drop_cnt  = drop_cnt_q;
  end
`endif

endmodule
